// File: rtl/dec_pkg.sv
// ---------------------------------------------------------------------------
// dec_pkg : shared widths, enums and parity-check matrix for the SECDED path.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package dec_pkg;

  localparam int CW_W   = 16;
  localparam int DATA_W = 11;
  localparam int SYN_W  = 5;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_CORR = 2'd2,
    ST_OUT  = 2'd3
  } dec_state_t;

  typedef enum logic [1:0] {
    DEC_CLEAN  = 2'b00,
    DEC_SINGLE = 2'b01,
    DEC_DOUBLE = 2'b10
  } dec_status_t;

  // Row r selects the codeword bits whose locator code has bit r set; row 4 is overall parity.
  localparam logic [SYN_W-1:0][CW_W-1:0] H_ROWS = {
    16'hFFFF, 16'hFE08, 16'hF1C4, 16'hCDA2, 16'hAB61
  };

endpackage

`default_nettype wire

// File: rtl/dec_mat_multiplier_16bit.sv
// ---------------------------------------------------------------------------
// dec_mat_multiplier_16bit : GF(2) product of the parity-check matrix and a codeword.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dec_mat_multiplier_16bit
  import dec_pkg::*;
(
  input  logic [CW_W-1:0]  cw_i,
  output logic [SYN_W-1:0] syn_o
);

  generate
    for (genvar r = 0; r < SYN_W; r++) begin : g_row
      assign syn_o[r] = ^(cw_i & H_ROWS[r]);
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/dec_syndrome_locator.sv
// ---------------------------------------------------------------------------
// dec_syndrome_locator : classifies a syndrome and maps it to the failing bit index.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dec_syndrome_locator
  import dec_pkg::*;
(
  input  logic [SYN_W-1:0] syn_i,
  output logic [1:0]       status_o,
  output logic [3:0]       pos_o
);

  logic [3:0] w_loc;

  always_comb begin
    w_loc = 4'd0;
    case (syn_i[3:0])
      4'b0000: w_loc = 4'd4;
      4'b0001: w_loc = 4'd0;
      4'b0010: w_loc = 4'd1;
      4'b0100: w_loc = 4'd2;
      4'b1000: w_loc = 4'd3;
      4'b0011: w_loc = 4'd5;
      4'b0101: w_loc = 4'd6;
      4'b0110: w_loc = 4'd7;
      4'b0111: w_loc = 4'd8;
      4'b1001: w_loc = 4'd9;
      4'b1010: w_loc = 4'd10;
      4'b1011: w_loc = 4'd11;
      4'b1100: w_loc = 4'd12;
      4'b1101: w_loc = 4'd13;
      4'b1110: w_loc = 4'd14;
      default: w_loc = 4'd15;
    endcase
  end

  // Overall-parity failure means an odd number of flips, taken as a single error.
  always_comb begin
    status_o = DEC_CLEAN;
    pos_o    = 4'd0;
    if (syn_i[4]) begin
      status_o = DEC_SINGLE;
      pos_o    = w_loc;
    end else if (syn_i[3:0] != 4'd0) begin
      status_o = DEC_DOUBLE;
    end
  end

endmodule

`default_nettype wire

// File: rtl/dec_ctrl_16bit.sv
// ---------------------------------------------------------------------------
// dec_ctrl_16bit : SECDED decode sequencer (IDLE/CALC/CORR/OUT) with handshakes.
// Optional error counters built when DEC_ERR_COUNTERS_EN is defined.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dec_ctrl_16bit
  import dec_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CW_W-1:0]   in_codeword,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CW_W-1:0]   out_codeword,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_status,
  output logic [3:0]        out_err_pos
`ifdef DEC_ERR_COUNTERS_EN
  ,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  cnt_single,
  output logic [CNT_W-1:0]  cnt_double
`endif
);

  dec_state_t       state_q, state_d;
  logic [CW_W-1:0]  cw_q;
  logic [SYN_W-1:0] syn_q;
  logic [CW_W-1:0]  out_cw_q;
  logic [1:0]       out_status_q;
  logic [3:0]       out_pos_q;

  logic [SYN_W-1:0] w_syn;
  logic [1:0]       w_status;
  logic [3:0]       w_pos;
  logic [CW_W-1:0]  w_corr_cw;
  logic             w_cap_en;
  logic             w_syn_en;
  logic             w_corr_en;

  dec_mat_multiplier_16bit u_mult (
    .cw_i  (cw_q),
    .syn_o (w_syn)
  );

  dec_syndrome_locator u_loc (
    .syn_i    (syn_q),
    .status_o (w_status),
    .pos_o    (w_pos)
  );

  assign w_corr_cw = (w_status == DEC_SINGLE) ? (cw_q ^ (CW_W'(1) << w_pos)) : cw_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid) state_d = ST_CALC;
      ST_CALC: state_d = ST_CORR;
      ST_CORR: state_d = ST_OUT;
      ST_OUT:  if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // in_ready is masked by rst so the producer never sees it high during reset.
  always_comb begin
    in_ready  = (state_q == ST_IDLE) && !rst;
    out_valid = (state_q == ST_OUT);
    w_cap_en  = (state_q == ST_IDLE) && in_valid;
    w_syn_en  = (state_q == ST_CALC);
    w_corr_en = (state_q == ST_CORR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cw_q         <= '0;
      syn_q        <= '0;
      out_cw_q     <= '0;
      out_status_q <= DEC_CLEAN;
      out_pos_q    <= '0;
    end else begin
      if (w_cap_en) cw_q  <= in_codeword;
      if (w_syn_en) syn_q <= w_syn;
      if (w_corr_en) begin
        out_cw_q     <= w_corr_cw;
        out_status_q <= w_status;
        out_pos_q    <= w_pos;
      end
    end
  end

  assign out_codeword = out_cw_q;
  assign out_data     = out_cw_q[CW_W-1:CW_W-DATA_W];
  assign out_status   = out_status_q;
  assign out_err_pos  = out_pos_q;

`ifdef DEC_ERR_COUNTERS_EN
  logic [CNT_W-1:0] cnt_single_q;
  logic [CNT_W-1:0] cnt_double_q;

  // A clear wins over a same-cycle increment; the increment is dropped.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      cnt_single_q <= '0;
      cnt_double_q <= '0;
    end else if (w_corr_en) begin
      if (w_status == DEC_SINGLE && cnt_single_q != '1) cnt_single_q <= cnt_single_q + 1'b1;
      if (w_status == DEC_DOUBLE && cnt_double_q != '1) cnt_double_q <= cnt_double_q + 1'b1;
    end
  end

  assign cnt_single = cnt_single_q;
  assign cnt_double = cnt_double_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dec_ctrl_16bit.sv
// ---------------------------------------------------------------------------
// tb_dec_ctrl_16bit : self-checking bench with a transaction-level decode model.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dec_ctrl_16bit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_codeword = 16'h0000;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_codeword;
  logic [10:0] out_data;
  logic [1:0]  out_status;
  logic [3:0]  out_err_pos;
`ifdef DEC_ERR_COUNTERS_EN
  logic        cnt_clr = 1'b0;
  logic [15:0] cnt_single;
  logic [15:0] cnt_double;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dec_ctrl_16bit dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_codeword  (in_codeword),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_codeword (out_codeword),
    .out_data     (out_data),
    .out_status   (out_status),
    .out_err_pos  (out_err_pos)
`ifdef DEC_ERR_COUNTERS_EN
    ,
    .cnt_clr      (cnt_clr),
    .cnt_single   (cnt_single),
    .cnt_double   (cnt_double)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Locator code of each codeword bit as listed in the decode table.
  function automatic logic [3:0] col(input int i);
    case (i)
      0: col = 4'd1;   1: col = 4'd2;   2: col = 4'd4;   3: col = 4'd8;
      4: col = 4'd0;   5: col = 4'd3;   6: col = 4'd5;   7: col = 4'd6;
      8: col = 4'd7;   9: col = 4'd9;   10: col = 4'd10; 11: col = 4'd11;
      12: col = 4'd12; 13: col = 4'd13; 14: col = 4'd14; default: col = 4'd15;
    endcase
  endfunction

  task automatic decode(input logic [15:0] cw, output logic [15:0] cwo,
                        output logic [1:0] st, output logic [3:0] pos);
    logic [3:0] s;
    s   = 4'd0;
    cwo = cw;
    st  = 2'd0;
    pos = 4'd0;
    for (int i = 0; i < 16; i++) if (cw[i]) s ^= col(i);
    if (^cw) begin
      st = 2'd1;
      for (int i = 0; i < 16; i++) if (col(i) == s) pos = 4'(i);
      cwo[pos] = ~cwo[pos];
    end else if (s != 4'd0) begin
      st = 2'd2;
    end
  endtask

  // Model state: one transaction in flight, timed by the cycle it was accepted.
  int          cyc = 0;
  bit          started = 1'b0;
  bit          m_busy = 1'b0;
  int          m_acc = 0;
  logic [15:0] m_cw = 16'h0000;
  logic [15:0] e_cw = 16'h0000;
  logic [1:0]  e_st = 2'd0;
  logic [3:0]  e_pos = 4'd0;
  int          e_cs = 0;
  int          e_cd = 0;

  always @(posedge clk) begin
    logic clr;
    cyc++;
    started = 1'b1;
`ifdef DEC_ERR_COUNTERS_EN
    clr = cnt_clr;
`else
    clr = 1'b0;
`endif
    if (rst) begin
      m_busy = 1'b0;
      e_cw = 16'h0000; e_st = 2'd0; e_pos = 4'd0;
      e_cs = 0; e_cd = 0;
    end else begin
      if (clr) begin e_cs = 0; e_cd = 0; end
      if (m_busy && (cyc - 1) >= m_acc + 3 && out_ready) begin
        m_busy = 1'b0;
      end else if (!m_busy && in_valid) begin
        m_busy = 1'b1;
        m_acc  = cyc - 1;
        m_cw   = in_codeword;
      end
      if (m_busy && cyc == m_acc + 3) begin
        decode(m_cw, e_cw, e_st, e_pos);
        if (!clr) begin
          if (e_st == 2'd1 && e_cs < 65535) e_cs++;
          if (e_st == 2'd2 && e_cd < 65535) e_cd++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("m_in_ready",  {31'd0, in_ready},  {31'd0, (!rst && !m_busy)});
      chk("m_out_valid", {31'd0, out_valid}, {31'd0, (m_busy && cyc >= m_acc + 3)});
      chk("m_codeword",  {16'd0, out_codeword}, {16'd0, e_cw});
      chk("m_data",      {21'd0, out_data},     {21'd0, e_cw[15:5]});
      chk("m_status",    {30'd0, out_status},   {30'd0, e_st});
      chk("m_err_pos",   {28'd0, out_err_pos},  {28'd0, e_pos});
`ifdef DEC_ERR_COUNTERS_EN
      chk("m_cnt_single", {16'd0, cnt_single}, 32'(e_cs));
      chk("m_cnt_double", {16'd0, cnt_double}, 32'(e_cd));
`endif
    end
  end

  // Called at posedge+1 with the DUT idle and out_ready high.
  task automatic run(input logic [15:0] cw, input logic [15:0] xcw,
                     input logic [1:0] xst, input logic [3:0] xpos);
    int n;
    in_valid = 1'b1;
    in_codeword = cw;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 8) begin @(posedge clk); #1; n++; end
    chk("latency", 32'(n), 32'd2);
    chk("lit_codeword", {16'd0, out_codeword}, {16'd0, xcw});
    chk("lit_data", {21'd0, out_data}, {21'd0, xcw[15:5]});
    chk("lit_status", {30'd0, out_status}, {30'd0, xst});
    chk("lit_err_pos", {28'd0, out_err_pos}, {28'd0, xpos});
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [15:0] v;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_codeword", {16'd0, out_codeword}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    run(16'h0033, 16'h0033, 2'd0, 4'd0);
    run(16'h0233, 16'h0033, 2'd1, 4'd9);
`ifdef DEC_ERR_COUNTERS_EN
    chk("lit_cnt_single_1", {16'd0, cnt_single}, 32'd1);
`endif
    run(16'h0023, 16'h0033, 2'd1, 4'd4);
    run(16'h0030, 16'h0030, 2'd2, 4'd0);
`ifdef DEC_ERR_COUNTERS_EN
    chk("lit_cnt_double_1", {16'd0, cnt_double}, 32'd1);
    chk("lit_cnt_single_2", {16'd0, cnt_single}, 32'd2);
`endif

    // Backpressure with a second codeword already waiting on the input.
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_codeword = 16'h0233;
    @(posedge clk); #1;
    in_codeword = 16'h7FFF;
    n = 0;
    while (out_valid !== 1'b1 && n < 8) begin @(posedge clk); #1; n++; end
    chk("bp_latency", 32'(n), 32'd2);
    repeat (5) begin
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_codeword", {16'd0, out_codeword}, 32'h0033);
      chk("bp_err_pos", {28'd0, out_err_pos}, 32'd9);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_drop_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_rise_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 8) begin @(posedge clk); #1; n++; end
    chk("bp2_latency", 32'(n), 32'd2);
    chk("bp2_codeword", {16'd0, out_codeword}, 32'hFFFF);
    chk("bp2_data", {21'd0, out_data}, 32'h7FF);
    chk("bp2_status", {30'd0, out_status}, 32'd1);
    chk("bp2_err_pos", {28'd0, out_err_pos}, 32'd15);
`ifdef DEC_ERR_COUNTERS_EN
    chk("lit_cnt_single_4", {16'd0, cnt_single}, 32'd4);
`endif
    @(posedge clk); #1;

    // Reset while the codeword sits in CORR.
    in_valid = 1'b1;
    in_codeword = 16'h0233;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_codeword", {16'd0, out_codeword}, 32'd0);
    chk("mid_rst_status", {30'd0, out_status}, 32'd0);
    chk("mid_rst_err_pos", {28'd0, out_err_pos}, 32'd0);
`ifdef DEC_ERR_COUNTERS_EN
    chk("mid_rst_cnt_single", {16'd0, cnt_single}, 32'd0);
    chk("mid_rst_cnt_double", {16'd0, cnt_double}, 32'd0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    run(16'h0233, 16'h0033, 2'd1, 4'd9);
    // Clear coinciding with the CORR->OUT increment.
    in_valid = 1'b1;
    in_codeword = 16'h0023;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
`ifdef DEC_ERR_COUNTERS_EN
    cnt_clr = 1'b1;
`endif
    @(posedge clk); #1;
`ifdef DEC_ERR_COUNTERS_EN
    cnt_clr = 1'b0;
    chk("clr_cnt_single", {16'd0, cnt_single}, 32'd0);
`endif
    chk("clr_status", {30'd0, out_status}, 32'd1);
    chk("clr_err_pos", {28'd0, out_err_pos}, 32'd4);
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) begin
      v = 16'h0033 ^ (16'd1 << i);
      run(v, 16'h0033, 2'd1, 4'(i));
    end
    for (int i = 0; i < 15; i++) begin
      v = 16'h0033 ^ (16'd3 << i);
      run(v, v, 2'd2, 4'd0);
    end
    run(16'hFFFF, 16'hFFFF, 2'd0, 4'd0);
    run(16'h0000, 16'h0000, 2'd0, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
